// File: rtl/alu112_if.sv
// alu112_if: operand/result bundle between the decode stage (master) and the
// alu112 datapath (slave). The registered flag outputs zero_q/neg_q/ovf_q
// exist only when ALU112_FLAGS_EN is defined.
interface alu112_if #(
  parameter int WIDTH = 8
);
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ci;
  logic [WIDTH-1:0] result;
  logic             co;
  logic [WIDTH-1:0] result_q;
  logic             co_q;
`ifdef ALU112_FLAGS_EN
  logic             zero_q;
  logic             neg_q;
  logic             ovf_q;
`endif

  // Decode stage: drives operation and operands, observes results.
  modport master (
    output op, A, B, ci,
    input  result, co, result_q, co_q
`ifdef ALU112_FLAGS_EN
    , input zero_q, neg_q, ovf_q
`endif
  );

  // ALU: consumes operation and operands, produces results.
  modport slave (
    input  op, A, B, ci,
    output result, co, result_q, co_q
`ifdef ALU112_FLAGS_EN
    , output zero_q, neg_q, ovf_q
`endif
  );
endinterface

// File: rtl/alu112.sv
// alu112: 8-opcode arithmetic/logic unit with carry-in and carry/borrow-out.
// result/co are combinational; result_q/co_q are the same values registered
// on every rising clk. Defining ALU112_FLAGS_EN adds registered zero/negative/
// signed-overflow flags.
module alu112 #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  alu112_if.slave    bus
);

  logic [WIDTH-1:0] result_d;
  logic             co_d;
  logic [WIDTH-1:0] result_q;
  logic             co_q;

  // Combinational datapath: all arithmetic done at WIDTH+1 bits, top bit is carry/borrow.
  always_comb begin
    result_d = '0;
    co_d     = 1'b0;
    unique case (bus.op)
      3'b000: {co_d, result_d} = {1'b0, bus.A} + {1'b0, bus.B};
      3'b001: {co_d, result_d} = {1'b0, bus.A} + {1'b0, bus.B}
                                 + {{WIDTH{1'b0}}, bus.ci};
      // Unsigned subtract wraps below zero, so the top bit is set exactly on borrow.
      3'b010: {co_d, result_d} = {1'b0, bus.A} - {1'b0, bus.B}
                                 - {{WIDTH{1'b0}}, bus.ci};
      3'b011: result_d = bus.A & bus.B;
      3'b100: result_d = bus.A | bus.B;
      3'b101: result_d = bus.A ^ bus.B;
      3'b110: result_d = ~bus.A;
      default: result_d = '0;
    endcase
  end

  assign bus.result = result_d;
  assign bus.co     = co_d;

  // Output register stage: loads every edge, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      co_q     <= 1'b0;
    end else begin
      result_q <= result_d;
      co_q     <= co_d;
    end
  end

  assign bus.result_q = result_q;
  assign bus.co_q     = co_q;

`ifdef ALU112_FLAGS_EN
  logic zero_d, neg_d, ovf_d;
  logic zero_q, neg_q, ovf_q;

  // Flag derivation; overflow only meaningful for the three arithmetic ops.
  always_comb begin
    zero_d = (result_d == '0);
    neg_d  = result_d[WIDTH-1];
    ovf_d  = 1'b0;
    unique case (bus.op)
      3'b000, 3'b001: ovf_d = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                              (result_d[WIDTH-1] != bus.A[WIDTH-1]);
      3'b010:         ovf_d = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                              (result_d[WIDTH-1] != bus.A[WIDTH-1]);
      default:        ovf_d = 1'b0;
    endcase
  end

  // Flag registers share the output stage's timing and reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      neg_q  <= neg_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.zero_q = zero_q;
  assign bus.neg_q  = neg_q;
  assign bus.ovf_q  = ovf_q;
`endif

endmodule

// File: tb/tb_alu112.sv
// tb_alu112: directed-vector bench for alu112 with hand-computed expectations.
// Flag checks are included when ALU112_FLAGS_EN is defined.
module tb_alu112;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] r;
    logic       co;
  } vec_t;

  localparam int NVEC = 15;

  // Hand-computed vectors.
  vec_t vecs [NVEC] = '{
    '{3'b000, 8'h57, 8'hB1, 1'b1, 8'h08, 1'b1},
    '{3'b001, 8'h57, 8'hB1, 1'b1, 8'h09, 1'b1},
    '{3'b010, 8'h57, 8'hB1, 1'b1, 8'hA5, 1'b1},
    '{3'b011, 8'h57, 8'hB1, 1'b1, 8'h11, 1'b0},
    '{3'b100, 8'h57, 8'hB1, 1'b1, 8'hF7, 1'b0},
    '{3'b101, 8'h57, 8'hB1, 1'b1, 8'hE6, 1'b0},
    '{3'b110, 8'h57, 8'hB1, 1'b1, 8'hA8, 1'b0},
    '{3'b000, 8'hF1, 8'hB1, 1'b1, 8'hA2, 1'b1},
    '{3'b001, 8'hF1, 8'hB1, 1'b1, 8'hA3, 1'b1},
    '{3'b010, 8'hF1, 8'hB1, 1'b1, 8'h3F, 1'b0},
    '{3'b011, 8'hF1, 8'hB1, 1'b1, 8'hB1, 1'b0},
    '{3'b100, 8'hF1, 8'hB1, 1'b1, 8'hF1, 1'b0},
    '{3'b101, 8'hF1, 8'hB1, 1'b1, 8'h40, 1'b0},
    '{3'b110, 8'hF1, 8'hB1, 1'b1, 8'h0E, 1'b0},
    '{3'b111, 8'hF1, 8'hB1, 1'b1, 8'h00, 1'b0}
  };

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  alu112_if #(.WIDTH(8)) bus ();

  alu112 #(.WIDTH(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic ci);
    bus.op = op;
    bus.A  = a;
    bus.B  = b;
    bus.ci = ci;
  endtask

  initial begin
    rst_n = 1'b1;
    drive(3'b000, 8'h00, 8'h00, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("reset result_q", 32'(bus.result_q), 32'h0);
    check("reset co_q", 32'(bus.co_q), 32'h0);
`ifdef ALU112_FLAGS_EN
    check("reset zero_q", 32'(bus.zero_q), 32'h0);
    check("reset neg_q", 32'(bus.neg_q), 32'h0);
    check("reset ovf_q", 32'(bus.ovf_q), 32'h0);
`endif

    // Combinational path keeps tracking while held in reset.
    drive(3'b000, 8'h57, 8'hB1, 1'b1);
    @(posedge clk);
    #1;
    check("in-reset result", 32'(bus.result), 32'h08);
    check("in-reset co", 32'(bus.co), 32'h1);
    check("in-reset result_q held", 32'(bus.result_q), 32'h0);

    // First edge after release captures the current combinational values.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release result_q", 32'(bus.result_q), 32'h08);
    check("release co_q", 32'(bus.co_q), 32'h1);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ci);
      #1;
      $display("[TB] vec %0d op=%b A=%h B=%h ci=%b -> result=%h co=%b (exp %h/%b)",
               i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ci,
               bus.result, bus.co, vecs[i].r, vecs[i].co);
      check($sformatf("v%0d result", i), 32'(bus.result), 32'(vecs[i].r));
      check($sformatf("v%0d co", i), 32'(bus.co), 32'(vecs[i].co));
      @(posedge clk);
      #1;
      check($sformatf("v%0d result_q", i), 32'(bus.result_q), 32'(vecs[i].r));
      check($sformatf("v%0d co_q", i), 32'(bus.co_q), 32'(vecs[i].co));
    end

    // Add-with-carry wrap into co, observed one edge later.
    @(negedge clk);
    drive(3'b001, 8'hFF, 8'h00, 1'b1);
    #1;
    check("adc wrap result_q not yet", 32'(bus.result_q), 32'h00);
    check("adc wrap co_q not yet", 32'(bus.co_q), 32'h0);
    @(posedge clk);
    #1;
    $display("[TB] adc FF+00+1 -> result_q=%h co_q=%b", bus.result_q, bus.co_q);
    check("adc wrap result_q", 32'(bus.result_q), 32'h00);
    check("adc wrap co_q", 32'(bus.co_q), 32'h1);

    // Asynchronous reset between edges clears immediately.
    #2 rst_n = 1'b0;
    #1;
    $display("[TB] async reset mid-cycle -> result_q=%h co_q=%b", bus.result_q, bus.co_q);
    check("async rst result_q", 32'(bus.result_q), 32'h0);
    check("async rst co_q", 32'(bus.co_q), 32'h0);
    check("async rst comb co", 32'(bus.co), 32'h1);

`ifdef ALU112_FLAGS_EN
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'b000, 8'h7F, 8'h01, 1'b0);
    @(posedge clk);
    #1;
    $display("[TB] flags 7F+01 -> result_q=%h z=%b n=%b v=%b",
             bus.result_q, bus.zero_q, bus.neg_q, bus.ovf_q);
    check("flags add result_q", 32'(bus.result_q), 32'h80);
    check("flags add neg_q", 32'(bus.neg_q), 32'h1);
    check("flags add ovf_q", 32'(bus.ovf_q), 32'h1);
    check("flags add zero_q", 32'(bus.zero_q), 32'h0);
    @(negedge clk);
    drive(3'b010, 8'h10, 8'h10, 1'b0);
    @(posedge clk);
    #1;
    $display("[TB] flags 10-10 -> result_q=%h z=%b n=%b v=%b",
             bus.result_q, bus.zero_q, bus.neg_q, bus.ovf_q);
    check("flags sub zero_q", 32'(bus.zero_q), 32'h1);
    check("flags sub neg_q", 32'(bus.neg_q), 32'h0);
    check("flags sub ovf_q", 32'(bus.ovf_q), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
